lnic_net_rx_buffer: RTL and testbench

Store-and-forward receive buffer on the hardware side of the simulated network link, consuming the `net_in` stream (valid/data/keep/last, no ready) and presenting whole packets downstream on a ready/valid stream. The link cannot be backpressured, so the block stores each packet as it arrives and releases it only after its last beat. If a packet does not fit, the whole packet is dropped. It sits between the network endpoint and the NIC ingress pipeline.

---
 rtl/lnic_net_rx_buffer.sv | 118 +++++++++++
 tb/tb_lnic_net_rx_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lnic_net_rx_buffer.sv
// rtl/lnic_net_rx_buffer.sv - store-and-forward receive buffer with whole-packet drop on overflow
module lnic_net_rx_buffer #(
    parameter int DEPTH = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        net_in_valid,
    input  logic [63:0] net_in_bits_data,
    input  logic [7:0]  net_in_bits_keep,
    input  logic        net_in_bits_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_bits_data,
    output logic [7:0]  out_bits_keep,
    output logic        out_bits_last,
    output logic [31:0] rx_pkt_count,
    output logic [31:0] rx_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [72:0] mem [DEPTH];

    // wr_spec runs ahead through the packet being received; wr_commit only
    // moves on a last beat, so the reader never sees a partial packet.
    logic [AW:0] wr_spec;
    logic [AW:0] wr_commit;
    logic [AW:0] rd;

    logic full;
    logic accept;
    logic commit_now;
    logic drop_now;
    logic rd_fire;

    // Free space comes from pre-edge pointers: a read on this edge does not
    // make room for this edge's write.
    assign full      = ((wr_spec - rd) == CAP);
    assign out_valid = (rd != wr_commit);
    assign rd_fire   = out_valid && out_ready;
    assign {out_bits_last, out_bits_keep, out_bits_data} = mem[rd[AW-1:0]];

    // Next-state and per-beat decisions for the receive FSM
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit_now = 1'b0;
        drop_now   = 1'b0;
        if (net_in_valid) begin
            case (state)
                IDLE, RECV: begin
                    if (full) begin
                        drop_now   = 1'b1;
                        state_next = net_in_bits_last ? IDLE : DROP;
                    end else begin
                        accept = 1'b1;
                        if (net_in_bits_last) begin
                            commit_now = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = RECV;
                        end
                    end
                end
                DROP: begin
                    if (net_in_bits_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state, pointers and packet counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wr_spec       <= '0;
            wr_commit     <= '0;
            rd            <= '0;
            rx_pkt_count  <= '0;
            rx_drop_count <= '0;
        end else begin
            state <= state_next;
            if (drop_now) begin
                wr_spec       <= wr_commit;
                rx_drop_count <= rx_drop_count + 32'd1;
            end else if (accept) begin
                wr_spec <= wr_spec + 1'b1;
            end
            if (commit_now) begin
                wr_commit    <= wr_spec + 1'b1;
                rx_pkt_count <= rx_pkt_count + 32'd1;
            end
            if (rd_fire) begin
                rd <= rd + 1'b1;
            end
        end
    end

    // Beat storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem[wr_spec[AW-1:0]] <= {net_in_bits_last, net_in_bits_keep, net_in_bits_data};
        end
    end

endmodule

// File: tb/tb_lnic_net_rx_buffer.sv
// tb/tb_lnic_net_rx_buffer.sv - self-checking bench for lnic_net_rx_buffer
module tb_lnic_net_rx_buffer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        net_in_valid = 1'b0;
    logic [63:0] net_in_bits_data = '0;
    logic [7:0]  net_in_bits_keep = '0;
    logic        net_in_bits_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_bits_data;
    logic [7:0]  out_bits_keep;
    logic        out_bits_last;
    logic [31:0] rx_pkt_count;
    logic [31:0] rx_drop_count;

    lnic_net_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .net_in_valid     (net_in_valid),
        .net_in_bits_data (net_in_bits_data),
        .net_in_bits_keep (net_in_bits_keep),
        .net_in_bits_last (net_in_bits_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_bits_data    (out_bits_data),
        .out_bits_keep    (out_bits_keep),
        .out_bits_last    (out_bits_last),
        .rx_pkt_count     (rx_pkt_count),
        .rx_drop_count    (rx_drop_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    // Model: committed beats awaiting readout, and the packet still arriving
    beat_t       cq[$];
    beat_t       pq[$];
    bit          m_dropping = 1'b0;
    int unsigned m_pkt = 0;
    int unsigned m_drop = 0;
    int          occ;
    beat_t       got[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level model of buffer occupancy, commit and drop
    always @(posedge clock) begin
        if (reset) begin
            cq.delete();
            pq.delete();
            m_dropping = 1'b0;
            m_pkt = 0;
            m_drop = 0;
        end else begin
            occ = cq.size() + pq.size();
            if (cq.size() != 0 && out_ready) void'(cq.pop_front());
            if (net_in_valid) begin
                if (m_dropping) begin
                    if (net_in_bits_last) m_dropping = 1'b0;
                end else if (occ == DEPTH) begin
                    pq.delete();
                    m_drop++;
                    if (!net_in_bits_last) m_dropping = 1'b1;
                end else begin
                    pq.push_back({net_in_bits_last, net_in_bits_keep, net_in_bits_data});
                    if (net_in_bits_last) begin
                        foreach (pq[i]) cq.push_back(pq[i]);
                        pq.delete();
                        m_pkt++;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, and log accepted output beats
    always @(negedge clock) begin
        if (!reset) begin
            chk("out_valid", 64'(out_valid), 64'(cq.size() != 0));
            if (cq.size() != 0) begin
                chk("out_data", out_bits_data, cq[0].data);
                chk("out_keep", 64'(out_bits_keep), 64'(cq[0].keep));
                chk("out_last", 64'(out_bits_last), 64'(cq[0].last));
            end
            chk("pkt_count", 64'(rx_pkt_count), 64'(m_pkt));
            chk("drop_count", 64'(rx_drop_count), 64'(m_drop));
            if (out_valid && out_ready) got.push_back({out_bits_last, out_bits_keep, out_bits_data});
        end
    end

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        net_in_valid = 1'b1;
        net_in_bits_data = d;
        net_in_bits_keep = k;
        net_in_bits_last = l;
        @(posedge clock);
        #1;
        net_in_valid = 1'b0;
        net_in_bits_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        idle(2);
        reset = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_pkt", 64'(rx_pkt_count), 64'd0);
        chk("reset_drop", 64'(rx_drop_count), 64'd0);

        // Basic packet
        out_ready = 1'b1;
        got.delete();
        send(64'h11, 8'hFF, 1'b0);
        send(64'h22, 8'hFF, 1'b0);
        chk("basic_not_early", 64'(out_valid), 64'd0);
        send(64'h33, 8'h0F, 1'b1);
        chk("basic_commit_lat", 64'(out_valid), 64'd1);
        idle(4);
        chk("basic_n", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("basic_d0", got[0].data, 64'h11);
            chk("basic_d1", got[1].data, 64'h22);
            chk("basic_d2", got[2].data, 64'h33);
            chk("basic_k2", 64'(got[2].keep), 64'h0F);
            chk("basic_l1", 64'(got[1].last), 64'd0);
            chk("basic_l2", 64'(got[2].last), 64'd1);
        end
        chk("basic_pkt", 64'(rx_pkt_count), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        got.delete();
        send(64'h11, 8'hFF, 1'b0);
        send(64'h22, 8'hFF, 1'b0);
        send(64'h33, 8'h0F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", out_bits_data, 64'h11);
            idle(1);
        end
        out_ready = 1'b1;
        idle(4);
        chk("bp_n", 64'(got.size()), 64'd3);
        if (got.size() == 3) chk("bp_d2", got[2].data, 64'h33);

        // Overflow drop then recovery
        do_reset();
        out_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 5; i++) send(64'h50 + 64'(i), 8'hFF, 1'(i == 4));
        for (int i = 0; i < 4; i++) send(64'h60 + 64'(i), 8'hFF, 1'(i == 3));
        chk("ovf_drop", 64'(rx_drop_count), 64'd1);
        chk("ovf_pkt", 64'(rx_pkt_count), 64'd1);
        out_ready = 1'b1;
        idle(8);
        chk("ovf_n", 64'(got.size()), 64'd5);
        if (got.size() == 5) begin
            chk("ovf_d4", got[4].data, 64'h54);
            chk("ovf_l4", 64'(got[4].last), 64'd1);
        end
        send(64'hA0, 8'hFF, 1'b0);
        send(64'hA1, 8'hFF, 1'b1);
        idle(3);
        chk("rec_n", 64'(got.size()), 64'd7);
        if (got.size() == 7) begin
            chk("rec_d5", got[5].data, 64'hA0);
            chk("rec_d6", got[6].data, 64'hA1);
            chk("rec_l6", 64'(got[6].last), 64'd1);
        end
        chk("rec_pkt", 64'(rx_pkt_count), 64'd2);

        // Oversize packet
        do_reset();
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 9; i++) send(64'h70 + 64'(i), 8'hFF, 1'(i == 8));
        chk("big_none", 64'(got.size()), 64'd0);
        chk("big_drop", 64'(rx_drop_count), 64'd1);
        send(64'hC0, 8'h00, 1'b1);
        idle(2);
        chk("big_next_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            chk("big_next_d", got[0].data, 64'hC0);
            chk("big_next_k", 64'(got[0].keep), 64'h00);
        end

        // Reset mid-packet
        do_reset();
        out_ready = 1'b0;
        send(64'hB0, 8'hFF, 1'b0);
        send(64'hB1, 8'hFF, 1'b1);
        send(64'hB2, 8'hFF, 1'b0);
        send(64'hB3, 8'hFF, 1'b0);
        do_reset();
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_pkt", 64'(rx_pkt_count), 64'd0);
        chk("mid_drop", 64'(rx_drop_count), 64'd0);
        out_ready = 1'b1;
        got.delete();
        send(64'hBB, 8'hFF, 1'b1);
        idle(3);
        chk("mid_n", 64'(got.size()), 64'd1);
        if (got.size() == 1) begin
            chk("mid_d", got[0].data, 64'hBB);
            chk("mid_l", 64'(got[0].last), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
